// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg: flow codes, uop field positions and sequencer states
package dzcpu_useq_pkg;
  localparam logic [3:0] FL_OP           = 4'd0;
  localparam logic [3:0] FL_INC          = 4'd1;
  localparam logic [3:0] FL_EOF          = 4'd2;
  localparam logic [3:0] FL_INC_EOF      = 4'd3;
  localparam logic [3:0] FL_EOF_FU       = 4'd4;
  localparam logic [3:0] FL_INC_EOF_FU   = 4'd5;
  localparam logic [3:0] FL_INC_EOF_Z    = 4'd6;
  localparam logic [3:0] FL_INC_EOF_NZ   = 4'd7;
  localparam logic [3:0] FL_UPDATE_FLAGS = 4'd8;
  localparam logic [4:0] OP_JCB = 5'h0A;
  localparam int FLOW_MSB = 12;
  localparam int FLOW_LSB = 9;
  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 4;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_CBWAIT, S_CBDEC} state_t;
endpackage

// File: rtl/dzcpu_useq_flowdec.sv
// dzcpu_useq_flowdec: decodes a uop flow field and Z into pc-inc, flag-update and end-of-flow
module dzcpu_useq_flowdec
  import dzcpu_useq_pkg::*;
(
  input  logic [3:0] i_flow,
  input  logic       i_flag_z,
  output logic       o_pc_inc,
  output logic       o_flags_upd,
  output logic       o_end_flow
);
  logic [2:0] w_dec;
  // {pc_inc, flags_upd, end_flow}; undefined codes 9..15 behave as a plain advance
  always_comb begin
    w_dec = 3'b000;
    case (i_flow)
      FL_OP:           w_dec = 3'b000;
      FL_INC:          w_dec = 3'b100;
      FL_EOF:          w_dec = 3'b001;
      FL_INC_EOF:      w_dec = 3'b101;
      FL_EOF_FU:       w_dec = 3'b011;
      FL_INC_EOF_FU:   w_dec = 3'b111;
      FL_INC_EOF_Z:    w_dec = {2'b10, i_flag_z};
      FL_INC_EOF_NZ:   w_dec = {2'b10, !i_flag_z};
      FL_UPDATE_FLAGS: w_dec = 3'b010;
      default:         w_dec = 3'b000;
    endcase
  end
  assign {o_pc_inc, o_flags_upd, o_end_flow} = w_dec;
endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer that walks flow-indexed ROM addresses and issues uops
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter logic [7:0] INT_FLOW_IDX = 8'd238,
  parameter int         UOP_W        = 13
) (
  input  logic             iClock,
  input  logic             iReset_n,
  input  logic [7:0]       iMemData,
  input  logic             iStall,
  input  logic             iFlagZ,
  input  logic             iIntReq,
  input  logic             iIntEnable,
  input  logic [7:0]       iFlowIdx,
  input  logic [7:0]       iCbFlowIdx,
  input  logic [UOP_W-1:0] iUop,
  output logic [7:0]       oMop,
  output logic [7:0]       oUopAddr,
  output logic [UOP_W-1:0] oUop,
  output logic             oUopValid,
  output logic             oPcInc,
  output logic             oFlagsUpdate,
  output logic             oIntAck,
  output logic             oUopErr
);
  state_t     r_state, w_state;
  logic [7:0] r_uop_addr, w_uop_addr, r_mop, w_mop;
  logic       r_cb, w_cb, r_err, w_err;
  logic       w_pc_inc, w_flags_upd, w_end_flow, w_jcb, w_int;
  assign w_jcb = iUop[OP_MSB:OP_LSB] == OP_JCB;
  assign w_int = iIntReq & iIntEnable;
  dzcpu_useq_flowdec u_flowdec (
    .i_flow      (iUop[FLOW_MSB:FLOW_LSB]),
    .i_flag_z    (iFlagZ),
    .o_pc_inc    (w_pc_inc),
    .o_flags_upd (w_flags_upd),
    .o_end_flow  (w_end_flow)
  );
  // sequencer registers; a stall is handled by the next-state logic holding every value
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state    <= S_FETCH;
      r_uop_addr <= 8'd0;
      r_mop      <= 8'd0;
      r_cb       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_uop_addr <= w_uop_addr;
      r_mop      <= w_mop;
      r_cb       <= w_cb;
      r_err      <= w_err;
    end
  end
  // next state and issue strobes; JCB outranks the flow end, and address 255 never wraps
  always_comb begin
    w_state      = r_state;
    w_uop_addr   = r_uop_addr;
    w_mop        = r_mop;
    w_cb         = r_cb;
    w_err        = r_err;
    oUopValid    = 1'b0;
    oPcInc       = 1'b0;
    oFlagsUpdate = 1'b0;
    oIntAck      = 1'b0;
    if (!iStall) begin
      case (r_state)
        S_FETCH:  w_state = S_DECODE;
        S_DECODE: begin
          w_mop      = iMemData;
          w_uop_addr = iFlowIdx;
          w_state    = S_EXEC;
        end
        S_EXEC: begin
          oUopValid    = 1'b1;
          oPcInc       = w_pc_inc;
          oFlagsUpdate = w_flags_upd;
          if (w_jcb) begin
            w_cb    = 1'b1;
            w_state = S_CBWAIT;
          end else if (w_end_flow) begin
            oIntAck    = w_int;
            w_uop_addr = w_int ? INT_FLOW_IDX : r_uop_addr;
            w_state    = w_int ? S_EXEC : S_FETCH;
          end else if (r_uop_addr == 8'hFF) begin
            w_err   = 1'b1;
            w_state = S_FETCH;
          end else begin
            w_uop_addr = r_uop_addr + 8'd1;
          end
        end
        S_CBWAIT: w_state = S_CBDEC;
        S_CBDEC: begin
          w_uop_addr = iCbFlowIdx;
          w_cb       = 1'b0;
          w_state    = S_EXEC;
        end
        default: w_state = S_FETCH;
      endcase
    end
  end
  assign oMop     = (r_state == S_DECODE || r_state == S_CBDEC) ? iMemData : r_mop;
  assign oUopAddr = r_uop_addr;
  assign oUop     = oUopValid ? iUop : '0;
  assign oUopErr  = r_err;
endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: randomized and directed checks of the sequencer against a flow-walk model
module tb_dzcpu_useq;
  logic        iClock = 0, iReset_n = 0, iFlagZ = 0, iIntEnable = 0;
  logic [7:0]  iMemData = 0;
  logic        iStall, iIntReq;
  logic [7:0]  iFlowIdx, iCbFlowIdx, oMop, oUopAddr;
  logic [12:0] iUop, oUop;
  logic        oUopValid, oPcInc, oFlagsUpdate, oIntAck, oUopErr;
  logic [12:0] rom [256];
  logic [7:0]  lut [256];
  logic [7:0]  cblut [256];
  logic        man_stall = 0, rnd_stall = 0, int_req = 0, int_acked = 0;
  typedef struct packed {int t; logic [7:0] a; logic [12:0] u; logic pc; logic fu; logic ack; logic err;} ev_t;
  ev_t got_q[$], exp_q[$];
  int total = 0, bad = 0, steps = 0, cap_lim = 0, stall_mode = 0;

  always #5 iClock = ~iClock;
  assign iUop       = rom[oUopAddr];
  assign iFlowIdx   = lut[oMop];
  assign iCbFlowIdx = cblut[oMop];
  assign iStall     = stall_mode == 1 ? rnd_stall : man_stall;
  assign iIntReq    = int_req && !int_acked;

  dzcpu_useq dut (
    .iClock(iClock), .iReset_n(iReset_n), .iMemData(iMemData), .iStall(iStall),
    .iFlagZ(iFlagZ), .iIntReq(iIntReq), .iIntEnable(iIntEnable), .iFlowIdx(iFlowIdx),
    .iCbFlowIdx(iCbFlowIdx), .iUop(iUop), .oMop(oMop), .oUopAddr(oUopAddr), .oUop(oUop),
    .oUopValid(oUopValid), .oPcInc(oPcInc), .oFlagsUpdate(oFlagsUpdate), .oIntAck(oIntAck),
    .oUopErr(oUopErr)
  );

  // abstract time: number of unstalled clock edges since reset release
  always @(posedge iClock or negedge iReset_n)
    if (!iReset_n) steps <= 0;
    else if (!iStall) steps <= steps + 1;

  always @(posedge iClock) begin
    #1;
    rnd_stall = $urandom_range(0, 3) == 0;
  end

  always @(negedge iClock)
    if (iReset_n && oUopValid && steps < cap_lim)
      got_q.push_back('{steps, oUopAddr, oUop, oPcInc, oFlagsUpdate, oIntAck, oUopErr});

  // the request is withdrawn once the acknowledge has been clocked in
  always @(negedge iClock) begin
    if (!iReset_n) int_acked = 0;
    else if (oUopValid && oIntAck) begin
      @(posedge iClock);
      #1;
      int_acked = 1;
    end
  end

  task automatic do_reset();
    iReset_n = 0;
    repeat (2) @(posedge iClock);
    #1;
    iReset_n = 1;
  endtask

  task automatic run_steps(input int w);
    int n = 0;
    got_q.delete();
    cap_lim = w;
    while (steps < w && n < 4000) begin
      @(negedge iClock);
      n++;
    end
    cap_lim = 0;
    if (steps < w) begin
      total++; bad++;
      $display("FAIL run_timeout steps=%0d want %0d", steps, w);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 256; i++) begin
      rom[i]   = {4'd2, 5'($urandom_range(0, 9)), 4'($urandom)};
      lut[i]   = 8'($urandom);
      cblut[i] = 8'($urandom);
    end
  endtask

  // walks the ROM by the flow-code rules, listing every issue with its abstract time
  task automatic model(input int w, input logic [7:0] m, input logic z, input logic ip, input logic ime);
    int t = 2;
    logic [7:0] a;
    logic [3:0] f;
    logic pend, err, pc, fu, fin, ack, jcb;
    a = lut[m]; pend = ip; err = 0;
    exp_q.delete();
    while (t < w) begin
      f   = rom[a][12:9];
      jcb = rom[a][8:4] == 5'h0A;
      pc  = f inside {4'd1, 4'd3, 4'd5, 4'd6, 4'd7};
      fu  = f inside {4'd4, 4'd5, 4'd8};
      fin = (f >= 4'd2 && f <= 4'd5) || (f == 4'd6 && z) || (f == 4'd7 && !z);
      ack = !jcb && fin && pend && ime;
      exp_q.push_back('{t, a, rom[a], pc, fu, ack, err});
      if (jcb) begin a = cblut[m]; t += 3; end
      else if (ack) begin pend = 0; a = 8'd238; t += 1; end
      else if (fin) begin a = lut[m]; t += 3; end
      else if (a == 8'hFF) begin err = 1; a = lut[m]; t += 3; end
      else begin a = a + 8'd1; t += 1; end
    end
  endtask

  task automatic test_reset();
    fill();
    rom[0] = 13'h1FFF;
    iReset_n = 0; iMemData = 8'hFF; iFlagZ = 1; int_req = 1; iIntEnable = 1; man_stall = 0; stall_mode = 0;
    repeat (2) @(negedge iClock);
    total++;
    if ({oUopValid, oPcInc, oFlagsUpdate, oIntAck, oUopErr} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got %b want 00000", {oUopValid, oPcInc, oFlagsUpdate, oIntAck, oUopErr});
    end
    total++;
    if (oUopAddr !== 8'd0) begin bad++; $display("FAIL reset_addr got %h want 00", oUopAddr); end
    total++;
    if (oUop !== 13'd0) begin bad++; $display("FAIL reset_uop got %h want 0000", oUop); end
    total++;
    if (oMop !== 8'd0) begin bad++; $display("FAIL reset_mop got %h want 00", oMop); end
    int_req = 0; iIntEnable = 0;
  endtask

  task automatic test_nop();
    fill();
    lut[8'h00] = 8'd162; rom[162] = {4'd3, 5'd1, 4'd0};
    iMemData = 8'h00; iFlagZ = 1'($urandom); int_req = 0; iIntEnable = 0;
    do_reset(); run_steps(12); model(12, 8'h00, iFlagZ, 0, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL nop_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL nop[%0d] got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL nop[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_three_uop();
    fill();
    lut[8'h21] = 8'd23;
    rom[23] = {4'd1, 5'd2, 4'd1}; rom[24] = {4'd1, 5'd3, 4'd2}; rom[25] = {4'd2, 5'd4, 4'd3};
    iMemData = 8'h21;
    do_reset(); run_steps(14); model(14, 8'h21, iFlagZ, 0, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL three_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL three[%0d] got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL three[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_jrnz();
    for (int z = 0; z < 2; z++) begin
      fill();
      lut[8'h20] = 8'd17;
      rom[17] = {4'd0, 5'd1, 4'd0}; rom[18] = {4'd1, 5'd2, 4'd0}; rom[19] = {4'd6, 5'd3, 4'd0};
      rom[20] = {4'd0, 5'd4, 4'd0}; rom[21] = {4'd8, 5'd5, 4'd0}; rom[22] = {4'd2, 5'd6, 4'd0};
      iMemData = 8'h20; iFlagZ = z[0];
      do_reset(); run_steps(16); model(16, 8'h20, iFlagZ, 0, 0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL jrnz_z%0d_count got %0d want %0d", z, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        total++;
        if (i >= got_q.size()) begin bad++; $display("FAIL jrnz_z%0d[%0d] got none want %h", z, i, exp_q[i]); end
        else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL jrnz_z%0d[%0d] got %h want %h", z, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_cb();
    fill();
    lut[8'h7C] = 8'd15; cblut[8'h7C] = 8'd16;
    rom[15] = {4'($urandom_range(0, 8)), 5'h0A, 4'd0}; rom[16] = {4'd4, 5'd7, 4'd9};
    iMemData = 8'h7C; iFlagZ = 1'($urandom);
    do_reset(); run_steps(12); model(12, 8'h7C, iFlagZ, 0, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL cb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL cb[%0d] got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL cb[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    logic found = 0;
    fill();
    lut[8'h34] = 8'd40;
    rom[40] = {4'd0, 5'd1, 4'd0}; rom[41] = {4'd1, 5'd2, 4'd0}; rom[42] = {4'd2, 5'd3, 4'd0};
    iMemData = 8'h34; man_stall = 0;
    do_reset();
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge iClock);
      found = oUopValid && oUopAddr == 8'd40;
    end
    total++;
    if (!found) begin bad++; $display("FAIL stall_reach got none want addr 40 issued"); end
    @(posedge iClock);
    #1 man_stall = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge iClock);
      total++;
      if ({oUopValid, oPcInc, oUopAddr} !== {2'b00, 8'd41}) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%b pc=%b a=%0d want v=0 pc=0 a=41", k, oUopValid, oPcInc, oUopAddr);
      end
    end
    @(posedge iClock);
    #1 man_stall = 0;
    @(negedge iClock);
    total++;
    if ({oUopValid, oPcInc, oUopAddr} !== {2'b11, 8'd41}) begin
      bad++; $display("FAIL stall_resume got v=%b pc=%b a=%0d want v=1 pc=1 a=41", oUopValid, oPcInc, oUopAddr);
    end
    @(negedge iClock);
    total++;
    if ({oUopValid, oUopAddr} !== {1'b1, 8'd42}) begin
      bad++; $display("FAIL stall_next got v=%b a=%0d want v=1 a=42", oUopValid, oUopAddr);
    end
  endtask

  task automatic test_int();
    fill();
    lut[8'h44] = 8'd50;
    rom[50] = {4'd1, 5'd1, 4'd0}; rom[51] = {4'd2, 5'd2, 4'd0};
    rom[238] = {4'd1, 5'd3, 4'd0}; rom[239] = {4'd4, 5'd4, 4'd0};
    iMemData = 8'h44; int_req = 1; iIntEnable = 1;
    do_reset(); run_steps(14); model(14, 8'h44, iFlagZ, 1, 1);
    int_req = 0; iIntEnable = 0;
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL int_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL int[%0d] got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL int[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic found = 0;
    fill();
    lut[8'h55] = 8'd60; rom[0] = 13'h1FFF;
    for (int i = 60; i < 70; i++) rom[i] = {4'd1, 5'd5, 4'd0};
    rom[70] = {4'd2, 5'd6, 4'd0};
    iMemData = 8'h55;
    do_reset();
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge iClock);
      found = oUopValid && oUopAddr == 8'd62;
    end
    total++;
    if (!found) begin bad++; $display("FAIL rmid_reach got none want addr 62 issued"); end
    #2 iReset_n = 0;
    #1;
    total++;
    if ({oUopValid, oUopAddr, oUop, oMop, oPcInc, oFlagsUpdate, oIntAck, oUopErr} !== 38'd0) begin
      bad++; $display("FAIL rmid_outputs got v=%b a=%h u=%h m=%h pc=%b fu=%b ack=%b err=%b want all 0",
                      oUopValid, oUopAddr, oUop, oMop, oPcInc, oFlagsUpdate, oIntAck, oUopErr);
    end
    do_reset(); run_steps(16); model(16, 8'h55, iFlagZ, 0, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rmid_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL rmid[%0d] got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_runaway();
    fill();
    lut[8'h66] = 8'd254;
    rom[254] = {4'd0, 5'd1, 4'd0}; rom[255] = {4'd1, 5'd2, 4'd0};
    iMemData = 8'h66;
    do_reset(); run_steps(10); model(10, 8'h66, iFlagZ, 0, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL run_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL runaway[%0d] got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL runaway[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (oUopErr !== 1'b1) begin bad++; $display("FAIL runaway_sticky got %b want 1", oUopErr); end
  endtask

  task automatic test_random();
    logic [7:0] m;
    logic ip, ime;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 256; i++) begin
        rom[i]   = {4'($urandom), ($urandom_range(0, 9) == 0) ? 5'h0A : 5'($urandom_range(0, 9)), 4'($urandom)};
        lut[i]   = 8'($urandom);
        cblut[i] = 8'($urandom);
      end
      m = 8'($urandom); ip = 1'($urandom); ime = 1'($urandom);
      iMemData = m; iFlagZ = 1'($urandom); int_req = ip; iIntEnable = ime; stall_mode = 1;
      do_reset(); run_steps(40);
      stall_mode = 0;
      model(40, m, iFlagZ, ip, ime);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got %0d want %0d", it, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        total++;
        if (i >= got_q.size()) begin bad++; $display("FAIL rnd%0d[%0d] got none want %h", it, i, exp_q[i]); end
        else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d[%0d] got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
    end
    int_req = 0; iIntEnable = 0;
  endtask

  initial begin
    test_reset();
    test_nop();
    test_three_uop();
    test_jrnz();
    test_cb();
    test_stall();
    test_int();
    test_reset_mid();
    test_runaway();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
